// File: rtl/bmult_share_arb.sv
// Round-robin arbiter sharing one external 12x12 unsigned multiplier among N_REQ requesters,
// with credit-based in-order response FIFO. Optional op counter: BMULT_SHARE_ARB_STATS_EN.
module bmult_share_arb #(
  parameter int N_REQ     = 4,
  parameter int MULT_LAT  = 1,
  parameter int OUT_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [12*N_REQ-1:0]  req_a,
  input  logic [12*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic [11:0]          mult_a,
  output logic [11:0]          mult_b,
  input  logic [23:0]          mult_p,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2:0]           rsp_id,
  output logic [23:0]          rsp_p,
  output logic                 busy
`ifdef BMULT_SHARE_ARB_STATS_EN
  ,
  output logic [15:0]          op_cnt
`endif
);

  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(OUT_DEPTH - 1);

  logic [CW-1:0] credit_cnt;
  logic [CW-1:0] fifo_cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [2:0]    last_grant;

  logic          found_hi;
  logic          found_lo;
  logic [2:0]    idx_hi;
  logic [2:0]    idx_lo;
  logic [2:0]    grant_id;
  logic          can_grant;
  logic          grant;
  logic          push;
  logic          pop;

  logic [MULT_LAT-1:0]      tag_v;
  logic [MULT_LAT-1:0][2:0] tag_id;
  logic [26:0]              mem [OUT_DEPTH];
  logic [26:0]              head;

  // Two-pass round-robin: first valid index above last_grant, else first at or below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i]) begin
        if (i > int'(last_grant)) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            idx_hi   = 3'(i);
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          idx_lo   = 3'(i);
        end
      end
    end
  end

  // A pop in this cycle does not free a credit until the next cycle.
  assign can_grant = !rst && (credit_cnt < DEPTH_C);
  assign grant     = can_grant && (found_hi || found_lo);
  assign grant_id  = found_hi ? idx_hi : idx_lo;

  always_comb begin
    req_ready = '0;
    mult_a    = '0;
    mult_b    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant && grant_id == 3'(i)) begin
        req_ready[i] = 1'b1;
        mult_a       = req_a[12*i +: 12];
        mult_b       = req_b[12*i +: 12];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 3'(N_REQ - 1);
    end else if (grant) begin
      last_grant <= grant_id;
    end
  end

  // Tag pipeline tracks which requester owns the product emerging from the multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= grant;
      for (int i = 1; i < MULT_LAT; i++) tag_v[i] <= tag_v[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_id[0] <= grant_id;
    for (int i = 1; i < MULT_LAT; i++) tag_id[i] <= tag_id[i-1];
  end

  assign push = tag_v[MULT_LAT-1];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {tag_id[MULT_LAT-1], mult_p};
  end

  assign head      = mem[rd_ptr];
  assign rsp_valid = !rst && (fifo_cnt != '0);
  assign rsp_id    = rsp_valid ? head[26:24] : '0;
  assign rsp_p     = rsp_valid ? head[23:0]  : '0;
  assign pop       = rsp_valid && rsp_ready;
  assign busy      = !rst && (credit_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_cnt <= '0;
      fifo_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      case ({grant, pop})
        2'b10:   credit_cnt <= credit_cnt + CW'(1);
        2'b01:   credit_cnt <= credit_cnt - CW'(1);
        default: credit_cnt <= credit_cnt;
      endcase
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
    end
  end

`ifdef BMULT_SHARE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      op_cnt <= '0;
    end else if (grant && op_cnt != 16'hFFFF) begin
      op_cnt <= op_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bmult_share_arb.sv
// Directed and randomized checks for bmult_share_arb with a 1-cycle multiplier model.
module tb_bmult_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [47:0] req_a;
  logic [47:0] req_b;
  logic [3:0]  req_ready;
  logic [11:0] mult_a;
  logic [11:0] mult_b;
  logic [23:0] mult_p;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_id;
  logic [23:0] rsp_p;
  logic        busy;
`ifdef BMULT_SHARE_ARB_STATS_EN
  logic [15:0] op_cnt;
`endif

  int total = 0;
  int bad   = 0;

  bmult_share_arb #(.N_REQ(4), .MULT_LAT(1), .OUT_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p),
    .busy(busy)
`ifdef BMULT_SHARE_ARB_STATS_EN
    , .op_cnt(op_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) mult_p <= {12'd0, mult_a} * {12'd0, mult_b};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; req_a = 48'h123_456_789_ABC; req_b = 48'hFFF_FFF_FFF_FFF;
    rsp_ready = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready: got %b exp 0000", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b exp 0", busy); end
    total++; if ({mult_a, mult_b} !== 24'h0) begin bad++; $display("FAIL reset_mult_ops: got %h exp 000000", {mult_a, mult_b}); end
    total++; if ({rsp_id, rsp_p} !== 27'h0) begin bad++; $display("FAIL reset_rsp_data: got %h exp 0", {rsp_id, rsp_p}); end
    req_valid = '0;
    cyc();
  endtask

  task automatic test_single();
    rst = 1'b0;
    req_valid = 4'b0100; req_a = 48'h000_FFF_000_000; req_b = 48'h000_FFF_000_000; rsp_ready = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b exp 0100", req_ready); end
    total++; if ({mult_a, mult_b} !== 24'hFFF_FFF) begin bad++; $display("FAIL single_mult_ops: got %h exp fffFFF", {mult_a, mult_b}); end
    cyc(); req_valid = '0;
    @(negedge clk);
    total++; if ({rsp_valid, busy} !== 2'b01) begin bad++; $display("FAIL single_cycle1: got valid/busy %b exp 01", {rsp_valid, busy}); end
    cyc();
    @(negedge clk);
    total++; if ({rsp_valid, rsp_id, rsp_p} !== {1'b1, 3'd2, 24'hFFE001}) begin
      bad++; $display("FAIL single_rsp: got v=%b id=%0d p=%h exp v=1 id=2 p=ffe001", rsp_valid, rsp_id, rsp_p);
    end
    cyc();
    @(negedge clk);
    total++; if ({rsp_valid, busy} !== 2'b00) begin bad++; $display("FAIL single_idle: got valid/busy %b exp 00", {rsp_valid, busy}); end
  endtask

  task automatic test_round_robin();
    logic [23:0] exp_p [4];
    logic [3:0]  one;
    logic [3:0]  exp_rdy;
    exp_p[0] = 24'h00000F; exp_p[1] = 24'h00FFFF; exp_p[2] = 24'h001578; exp_p[3] = 24'h7FF800;
    one = 4'b0001;
    do_reset();
    req_valid = 4'hF; req_a = 48'h800_ABC_0FF_003; req_b = 48'hFFF_002_101_005; rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) req_valid = '0;
      @(negedge clk);
      if (k < 8) begin
        exp_rdy = one << (k % 4);
        total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_grant[%0d]: got %b exp %b", k, req_ready, exp_rdy); end
      end
      if (k >= 2) begin
        total++;
        if ({rsp_valid, rsp_id, rsp_p} !== {1'b1, 3'((k - 2) % 4), exp_p[(k - 2) % 4]}) begin
          bad++; $display("FAIL rr_rsp[%0d]: got v=%b id=%0d p=%h exp v=1 id=%0d p=%h",
                          k, rsp_valid, rsp_id, rsp_p, (k - 2) % 4, exp_p[(k - 2) % 4]);
        end
      end
      cyc();
    end
    @(negedge clk);
    total++; if ({rsp_valid, busy} !== 2'b00) begin bad++; $display("FAIL rr_idle: got valid/busy %b exp 00", {rsp_valid, busy}); end
  endtask

  task automatic test_backpressure();
    int hs;
    int n;
    do_reset();
    req_valid = 4'b0010; req_a = 48'h000_000_012_000; req_b = 48'h000_000_034_000; rsp_ready = 1'b0;
    hs = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) hs++;
      cyc();
    end
    total++; if (hs !== 4) begin bad++; $display("FAIL bp_handshakes: got %0d exp 4", hs); end
    rsp_ready = 1'b1;
    @(negedge clk);
    total++; if ({req_ready, busy} !== 5'b0000_1) begin bad++; $display("FAIL bp_full: got ready/busy %b exp 00001", {req_ready, busy}); end
    total++; if ({rsp_valid, rsp_id, rsp_p} !== {1'b1, 3'd1, 24'h0003A8}) begin
      bad++; $display("FAIL bp_head: got v=%b id=%0d p=%h exp v=1 id=1 p=0003a8", rsp_valid, rsp_id, rsp_p);
    end
    cyc(); rsp_ready = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_regrant: got %b exp 0010", req_ready); end
    cyc();
    @(negedge clk);
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_refull: got %b exp 0000", req_ready); end
    req_valid = '0; rsp_ready = 1'b1; n = 0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (rsp_valid) begin
        n++;
        total++; if ({rsp_id, rsp_p} !== {3'd1, 24'h0003A8}) begin
          bad++; $display("FAIL bp_drain: got id=%0d p=%h exp id=1 p=0003a8", rsp_id, rsp_p);
        end
      end
      cyc();
    end
    total++; if (n !== 4) begin bad++; $display("FAIL bp_drain_count: got %0d exp 4", n); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_busy_end: got %b exp 0", busy); end
  endtask

  task automatic test_full_pop();
    logic [23:0] exp_d [3];
    int n;
    exp_d[0] = 24'h000030; exp_d[1] = 24'h000040; exp_d[2] = 24'h000050;
    do_reset();
    req_valid = 4'b1000; req_b = 48'h010_000_000_000; rsp_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      req_a = {12'((k < 4) ? k + 1 : 5), 36'h0};
      @(negedge clk);
      cyc();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL full_no_grant: got %b exp 0000", req_ready); end
    total++; if ({rsp_valid, rsp_p} !== {1'b1, 24'h000010}) begin bad++; $display("FAIL full_head0: got v=%b p=%h exp v=1 p=000010", rsp_valid, rsp_p); end
    cyc();
    @(negedge clk);
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL full_next_grant: got %b exp 1000", req_ready); end
    total++; if ({rsp_valid, rsp_p} !== {1'b1, 24'h000020}) begin bad++; $display("FAIL full_head1: got v=%b p=%h exp v=1 p=000020", rsp_valid, rsp_p); end
    cyc();
    req_valid = '0; n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (n < 3) begin
          total++; if (rsp_p !== exp_d[n]) begin bad++; $display("FAIL full_drain[%0d]: got %h exp %h", n, rsp_p, exp_d[n]); end
        end
        n++;
      end
      cyc();
    end
    total++; if (n !== 3) begin bad++; $display("FAIL full_drain_count: got %0d exp 3", n); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_busy_end: got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    int stale;
    do_reset();
    req_valid = 4'b0001; req_a = 48'h000_000_000_123; req_b = 48'h000_000_000_456; rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cyc();
    end
    @(negedge clk);
    total++; if ({rsp_valid, busy} !== 2'b11) begin bad++; $display("FAIL mid_loaded: got valid/busy %b exp 11", {rsp_valid, busy}); end
    cyc();
    rst = 1'b1; req_valid = '0;
    cyc();
    rst = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    total++; if ({rsp_valid, busy} !== 2'b00) begin bad++; $display("FAIL mid_after_rst: got valid/busy %b exp 00", {rsp_valid, busy}); end
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid || busy) stale++;
      cyc();
    end
    total++; if (stale !== 0) begin bad++; $display("FAIL mid_stale: got %0d stale cycles exp 0", stale); end
    req_valid = 4'hF;
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_rr_restart: got %b exp 0001", req_ready); end
    cyc();
    req_valid = '0;
    repeat (4) cyc();
  endtask

  task automatic test_random();
    logic [26:0] sbq [$];
    logic [26:0] exp_e;
    int drain;
    do_reset();
    for (int c = 0; c < 12000; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_a     = 48'({$urandom(), $urandom()});
      req_b     = 48'({$urandom(), $urandom()});
      rsp_ready = ($urandom_range(0, 7) != 0);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i])
          sbq.push_back({3'(i), {12'd0, req_a[12*i +: 12]} * {12'd0, req_b[12*i +: 12]}});
      end
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          total++; bad++; $display("FAIL rand_unexpected: got id=%0d p=%h exp no response", rsp_id, rsp_p);
        end else begin
          exp_e = sbq.pop_front();
          total++; if ({rsp_id, rsp_p} !== exp_e) begin
            bad++; $display("FAIL rand_rsp[%0d]: got id=%0d p=%h exp id=%0d p=%h", c, rsp_id, rsp_p, exp_e[26:24], exp_e[23:0]);
          end
        end
      end
      cyc();
    end
    req_valid = '0; rsp_ready = 1'b1; drain = 0;
    while (sbq.size() != 0 && drain < 20) begin
      @(negedge clk);
      if (rsp_valid) begin
        exp_e = sbq.pop_front();
        total++; if ({rsp_id, rsp_p} !== exp_e) begin
          bad++; $display("FAIL rand_drain: got id=%0d p=%h exp id=%0d p=%h", rsp_id, rsp_p, exp_e[26:24], exp_e[23:0]);
        end
      end
      cyc();
      drain++;
    end
    total++; if (sbq.size() != 0) begin bad++; $display("FAIL rand_leftover: got %0d pending exp 0", sbq.size()); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rand_busy_end: got %b exp 0", busy); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
